// File: rtl/jk_pkg.sv
// jk_pkg: shared encodings for the JK bank driver (op codes, FSM states, attempt width).
package jk_pkg;
    typedef enum logic [1:0] {OP_LOAD, OP_CLEAR, OP_SET, OP_INVERT} op_e;
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_e;
    localparam int ATTEMPT_W = 3;
endpackage

// File: rtl/jk_excite.sv
// jk_excite: per-bit J/K excitation that moves q toward target; matching bits hold.
// JK_TOGGLE_EXCITE_EN selects toggle excitation (j=k=1) instead of set/reset form.
module jk_excite #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_target,
    output logic [W-1:0] o_j,
    output logic [W-1:0] o_k
);
    logic [W-1:0] w_diff;
    assign w_diff = i_q ^ i_target;
`ifdef JK_TOGGLE_EXCITE_EN
    assign o_j = w_diff;
    assign o_k = w_diff;
`else
    assign o_j = w_diff & i_target;
    assign o_k = w_diff & ~i_target;
`endif
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives an external JK flip-flop bank to a commanded word, verifies by readback, retries.
// Excitation form is selected by JK_TOGGLE_EXCITE_EN inside jk_excite.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [W-1:0]         cmd_data,
    input  logic [W-1:0]         q,
    output logic [W-1:0]         j,
    output logic [W-1:0]         k,
    output logic                 bank_en,
    output logic                 done,
    output logic                 error,
    output logic [ATTEMPT_W-1:0] attempts
);
    state_e               r_state, w_next;
    op_e                  w_op;
    logic [W-1:0]         r_target, w_target, w_j, w_k, r_j, r_k;
    logic                 r_bank_en, r_done, r_error, w_accept, w_match, w_retry;
    logic [ATTEMPT_W-1:0] r_attempts;

    assign w_op      = op_e'(cmd_op);
    assign cmd_ready = r_state == S_IDLE;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_match   = q == r_target;
    assign w_retry   = r_attempts <= ATTEMPT_W'(MAX_RETRY);
    // INVERT captures ~q as seen at the accept edge
    assign w_target  = !w_accept            ? r_target :
                       w_op == OP_LOAD      ? cmd_data :
                       w_op == OP_CLEAR     ? '0       :
                       w_op == OP_SET       ? '1       : ~q;

    jk_excite #(.W(W)) u_excite (
        .i_q      (q),
        .i_target (w_target),
        .o_j      (w_j),
        .o_k      (w_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_DRIVE : S_IDLE;
            S_DRIVE: w_next = S_CHECK;
            S_CHECK: w_next = (w_match || !w_retry) ? S_DONE : S_DRIVE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target   <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_bank_en  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_attempts <= '0;
        end else begin
            r_target  <= w_target;
            r_bank_en <= w_next == S_DRIVE;
            r_j       <= (w_next == S_DRIVE) ? w_j : '0;
            r_k       <= (w_next == S_DRIVE) ? w_k : '0;
            r_done    <= w_next == S_DONE;
            if (w_accept) r_attempts <= '0;
            else if (r_state == S_DRIVE && r_attempts != '1) r_attempts <= r_attempts + 1'b1;
            if (w_accept) r_error <= 1'b0;
            else if (r_state == S_CHECK && !w_match && !w_retry) r_error <= 1'b1;
        end
    end

    assign j        = r_j;
    assign k        = r_k;
    assign bank_en  = r_bank_en;
    assign done     = r_done;
    assign error    = r_error;
    assign attempts = r_attempts;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: table vectors, hand sequences and random commands against a JK bank model.
module tb_jk_bank_driver;
    localparam int W  = 8;
    localparam int MR = 2;

    logic         clk = 0, rst_n = 0, cmd_valid = 0, cmd_ready;
    logic [1:0]   cmd_op = 0;
    logic [W-1:0] cmd_data = 0, q_bank, j, k;
    logic         bank_en, done, error;
    logic [2:0]   attempts;
    logic         ld = 0;
    logic [W-1:0] ld_v = 0, stuck = 0, nx;
    int           en_count = 0, drop_at = -1;
    int           total = 0, bad = 0;

    jk_bank_driver #(.W(W), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .q(q_bank), .j(j), .k(k),
        .bank_en(bank_en), .done(done), .error(error), .attempts(attempts)
    );

    always #5 clk = ~clk;

    // JK bank: hold / reset / set / toggle per bit, with stuck-at-0 bits and a one-shot bit0 drop
    always @(posedge clk) begin
        if (ld) q_bank <= ld_v & ~stuck;
        else if (bank_en) begin
            for (int b = 0; b < W; b++)
                nx[b] = (j[b] && k[b]) ? ~q_bank[b] : j[b] ? 1'b1 : k[b] ? 1'b0 : q_bank[b];
            if (en_count == drop_at) nx[0] = 1'b0;
            q_bank   <= nx & ~stuck;
            en_count <= en_count + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_bank(input logic [W-1:0] v);
        @(negedge clk);
        ld_v = v;
        ld = 1;
        @(posedge clk);
        #1 ld = 0;
    endtask

    task automatic run_cmd(input string nm, input logic [1:0] op, input logic [W-1:0] d, qi, stk,
                           input bit drop, input logic [W-1:0] ej, ek, eq, input int eatt, input bit eerr);
        int n_en, n_done, dcyc;
        logic [W-1:0] mj, mk;
        logic rdy;
        stuck = stk;
        set_bank(qi);
        drop_at = drop ? en_count : -1;
        @(negedge clk);
        cmd_op = op; cmd_data = d; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        n_en = 0; n_done = 0; dcyc = -1; mj = 0; mk = 0; rdy = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bank_en) begin
                if (n_en == 0) begin mj = j; mk = k; end
                n_en++;
            end
            if (done) begin n_done++; dcyc = cyc; end
            if (dcyc >= 0 && cyc == dcyc + 1) begin rdy = cmd_ready; break; end
        end
        chk({nm, ".j"}, mj, ej);
        chk({nm, ".k"}, mk, ek);
        chk({nm, ".q"}, q_bank, eq);
        chk({nm, ".error"}, error, eerr);
        chk({nm, ".attempts"}, attempts, eatt);
        chk({nm, ".drives"}, n_en, eatt);
        chk({nm, ".done_pulses"}, n_done, 1);
        chk({nm, ".done_cycle"}, dcyc, 2 * eatt + 1);
        chk({nm, ".ready_after"}, rdy, 1);
    endtask

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [7:0] d, qi, stk;
        bit         drop;
        logic [7:0] ej, ek, eq;
        int         att;
        bit         err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n_en, n_done;
        logic [1:0] op;
        logic [W-1:0] d, qi, stk, q0, tgt, diff, ej, ek, qa;
        bit eerr;
        tbl[0] = '{"load_a5",  2'd0, 8'hA5, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 8'hA5, 1, 0};
        tbl[1] = '{"invert",   2'd3, 8'h00, 8'h3C, 8'h00, 0, 8'hC3, 8'h3C, 8'hC3, 1, 0};
        tbl[2] = '{"drop_b0",  2'd0, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h01, 2, 0};
        tbl[3] = '{"stuck_b7", 2'd2, 8'h00, 8'h00, 8'h80, 0, 8'hFF, 8'h00, 8'h7F, 3, 1};
        tbl[4] = '{"load_f0",  2'd0, 8'hF0, 8'h0F, 8'h00, 0, 8'hF0, 8'h0F, 8'hF0, 1, 0};
        tbl[5] = '{"clear",    2'd1, 8'hEE, 8'h5A, 8'h00, 0, 8'h00, 8'h5A, 8'h00, 1, 0};
        tbl[6] = '{"equal",    2'd0, 8'h66, 8'h66, 8'h00, 0, 8'h00, 8'h00, 8'h66, 1, 0};

        #2;
        chk("rst.cmd_ready", cmd_ready, 1);
        chk("rst.j", j, 0);
        chk("rst.k", k, 0);
        chk("rst.bank_en", bank_en, 0);
        chk("rst.done", done, 0);
        chk("rst.error", error, 0);
        chk("rst.attempts", attempts, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            ej = tbl[i].ej; ek = tbl[i].ek;
`ifdef JK_TOGGLE_EXCITE_EN
            ej = tbl[i].ej | tbl[i].ek;
            ek = ej;
`endif
            run_cmd(tbl[i].nm, tbl[i].op, tbl[i].d, tbl[i].qi, tbl[i].stk, tbl[i].drop,
                    ej, ek, tbl[i].eq, tbl[i].att, tbl[i].err);
        end

        // cmd_valid held high: one accept per IDLE visit
        stuck = 0; drop_at = -1;
        set_bank(8'h00);
        @(negedge clk);
        cmd_op = 2'd0; cmd_data = 8'h3C; cmd_valid = 1;
        @(posedge clk);
        n_en = 0; n_done = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bank_en) n_en++;
            if (done) n_done++;
            if (cyc == 8) cmd_valid = 0;
        end
        chk("hold.drives", n_en, 2);
        chk("hold.dones", n_done, 2);
        chk("hold.q", q_bank, 8'h3C);

        // reset asserted during DRIVE
        set_bank(8'h00);
        @(negedge clk);
        cmd_op = 2'd2; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
        @(negedge clk);
        chk("rstmid.drive_en", bank_en, 1);
        rst_n = 0;
        #1;
        chk("rstmid.bank_en", bank_en, 0);
        chk("rstmid.j", j, 0);
        chk("rstmid.k", k, 0);
        chk("rstmid.cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1;
        chk("rstmid.q", q_bank, 8'h00);

        for (int n = 0; n < 30; n++) begin
            op  = 2'($urandom_range(0, 3));
            d   = 8'($urandom);
            qi  = 8'($urandom);
            stk = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            q0  = qi & ~stk;
            tgt = op == 2'd0 ? d : op == 2'd1 ? 8'h00 : op == 2'd2 ? 8'hFF : ~q0;
            diff = q0 ^ tgt;
`ifdef JK_TOGGLE_EXCITE_EN
            ej = diff; ek = diff;
`else
            ej = diff & tgt; ek = diff & ~tgt;
`endif
            qa   = tgt & ~stk;
            eerr = qa != tgt;
            run_cmd("rand", op, d, qi, stk, 0, ej, ek, qa, eerr ? MR + 1 : 1, eerr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
